split_arbiter: RTL and testbench



---
 rtl/split_arbiter.sv | 101 ++++++++++
 tb/tb_split_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/split_arbiter.sv
// Two-master bus arbiter with grant timeout and split-transaction parking.
// A split master is masked until its slave resumes, then it wins the next grant.
module split_arbiter #(
  parameter int unsigned WAIT_MAX = 4
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic [1:0] B_REQ,
  input  logic       B_UTIL,
  input  logic       B_SPLIT,
  input  logic       B_SPL_RESUME,
  output logic [1:0] B_GRANT,
  output logic       B_DONE,
  output logic       B_BUSY,
  output logic       B_SPL_PEND
);

  typedef enum logic [1:0] {IDLE, WAIT, OWN} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);

  state_t     state;
  logic       last;
  logic       spl_id;
  logic       spl_ok;
  logic [3:0] wcnt;
  logic [1:0] elig;
  logic       winner;
  logic       owner;

  assign owner = B_GRANT[1];

  // A parked master stays masked until its slave has resumed.
  always_comb begin
    elig = B_REQ;
    if (B_SPL_PEND && !spl_ok) elig[spl_id] = 1'b0;
    winner = ~last;
    if (B_SPL_PEND && spl_ok && B_REQ[spl_id]) winner = spl_id;
    else if (elig == 2'b01) winner = 1'b0;
    else if (elig == 2'b10) winner = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= IDLE;
      B_GRANT    <= 2'b00;
      B_DONE     <= 1'b0;
      B_BUSY     <= 1'b0;
      B_SPL_PEND <= 1'b0;
      last       <= 1'b1;
      spl_id     <= 1'b0;
      spl_ok     <= 1'b0;
      wcnt       <= 4'd0;
    end else begin
      B_DONE <= 1'b0;
      // Later assignments below (split recorded, split master granted) override this.
      if (B_SPL_RESUME && B_SPL_PEND) spl_ok <= 1'b1;
      case (state)
        IDLE: begin
          if (|elig) begin
            state   <= WAIT;
            B_GRANT <= winner ? 2'b10 : 2'b01;
            B_BUSY  <= 1'b1;
            last    <= winner;
            wcnt    <= 4'd0;
            if (B_SPL_PEND && spl_ok && (winner == spl_id)) begin
              B_SPL_PEND <= 1'b0;
              spl_ok     <= 1'b0;
            end
          end
        end
        WAIT: begin
          wcnt <= wcnt + 4'd1;
          if (B_UTIL) begin
            state <= OWN;
          end else if (wcnt == WAIT_LAST) begin
            state   <= IDLE;
            B_GRANT <= 2'b00;
            B_BUSY  <= 1'b0;
            B_DONE  <= 1'b1;
          end
        end
        OWN: begin
          if (B_SPLIT || !B_UTIL) begin
            if (B_SPLIT && !B_SPL_PEND) begin
              spl_id     <= owner;
              B_SPL_PEND <= 1'b1;
              spl_ok     <= 1'b0;
            end
            state   <= IDLE;
            B_GRANT <= 2'b00;
            B_BUSY  <= 1'b0;
            B_DONE  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_split_arbiter.sv
// Randomized and directed bench for split_arbiter; a transaction-level model
// predicts each cycle's outputs into a queue that a negedge monitor drains.
module tb_split_arbiter;

  localparam int WAIT_MAX = 4;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic [1:0] B_REQ;
  logic       B_UTIL;
  logic       B_SPLIT;
  logic       B_SPL_RESUME;
  logic [1:0] B_GRANT;
  logic       B_DONE;
  logic       B_BUSY;
  logic       B_SPL_PEND;

  split_arbiter #(.WAIT_MAX(WAIT_MAX)) dut (
    .CLK(CLK), .RSTN(RSTN), .B_REQ(B_REQ), .B_UTIL(B_UTIL), .B_SPLIT(B_SPLIT),
    .B_SPL_RESUME(B_SPL_RESUME), .B_GRANT(B_GRANT), .B_DONE(B_DONE),
    .B_BUSY(B_BUSY), .B_SPL_PEND(B_SPL_PEND)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] grant;
    logic       done;
    logic       busy;
    logic       pend;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: owner -1 means bus free; split_master -1 means no split outstanding.
  int owner, last_win, split_master, age;
  bit used, resumed, done_pulse;

  function automatic void modelReset();
    owner = -1; last_win = 1; split_master = -1; age = 0;
    used = 0; resumed = 0; done_pulse = 0;
  endfunction

  function automatic exp_t modelStep(logic [1:0] req, logic util, logic split, logic resume);
    int   cand[$];
    int   win;
    bit   pend_before = (split_master >= 0);
    bit   split_rec = 0;
    bit   grant_split = 0;
    exp_t e;
    done_pulse = 0;
    if (owner < 0) begin
      for (int i = 0; i < 2; i++)
        if (req[i] && !(split_master == i && !resumed)) cand.push_back(i);
      if (cand.size() > 0) begin
        if (resumed && req[split_master]) win = split_master;
        else if (cand.size() == 1) win = cand[0];
        else win = 1 - last_win;
        owner = win; last_win = win; used = 0; age = 0;
        grant_split = (win == split_master);
      end
    end else if (!used) begin
      if (util) used = 1;
      else begin
        age++;
        if (age == WAIT_MAX) begin owner = -1; done_pulse = 1; end
      end
    end else if (split || !util) begin
      if (split && !pend_before) begin
        split_master = owner; split_rec = 1;
      end
      owner = -1; done_pulse = 1;
    end
    if (resume && pend_before && !split_rec) resumed = 1;
    if (split_rec || grant_split) resumed = 0;
    if (grant_split) split_master = -1;
    e.grant = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    e.done  = done_pulse;
    e.busy  = (owner >= 0);
    e.pend  = (split_master >= 0);
    return e;
  endfunction

  task automatic checkOutput(input exp_t e, input string name);
    exp_t act;
    act = {B_GRANT, B_DONE, B_BUSY, B_SPL_PEND};
    checks++;
    if (act !== e) begin
      errors++;
      if (errors <= 20)
        $display("[TB] FAIL %s t=%0t actual grant=%b done=%b busy=%b pend=%b required grant=%b done=%b busy=%b pend=%b",
                 name, $time, act.grant, act.done, act.busy, act.pend,
                 e.grant, e.done, e.busy, e.pend);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic util, input logic split,
                               input logic resume);
    exp_t e;
    B_REQ = req; B_UTIL = util; B_SPLIT = split; B_SPL_RESUME = resume;
    e = modelStep(req, util, split, resume);
    @(posedge CLK);
    #1;
    exp_q.push_back(e);
  endtask

  task automatic resetMid();
    @(negedge CLK);
    #1;
    B_REQ = 2'b00; B_UTIL = 1'b0; B_SPLIT = 1'b0; B_SPL_RESUME = 1'b0;
    RSTN = 1'b0;
    #1;
    checkOutput('0, "async_reset");
    modelReset();
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK)
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front(), "cycle");

  initial begin
    int bias;
    RSTN = 1'b0;
    B_REQ = 2'b00; B_UTIL = 1'b0; B_SPLIT = 1'b0; B_SPL_RESUME = 1'b0;
    modelReset();
    #12;
    checkOutput('0, "reset_values");
    @(negedge CLK);
    RSTN = 1'b1;
    @(posedge CLK);
    #1;

    // Reset in the middle of an owned transaction, then a tie goes to master 0.
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
    resetMid();
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0);

    resetMid();
    repeat (3) begin
      applyStimulus(2'b11, 1'b0, 1'b0, 1'b0);
      repeat (3) applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
      applyStimulus(2'b11, 1'b0, 1'b0, 1'b0);
    end

    resetMid();
    repeat (11) applyStimulus(2'b01, 1'b0, 1'b0, 1'b0);

    // Split by master 0, master 1 served, resume waits, master 0 regains the bus.
    resetMid();
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b1, 1'b1, 1'b0);
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b1);
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0);

    resetMid();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b10, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b10, 1'b0, 1'b1, 1'b0);
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b0, 1'b1, 1'b0);
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0);

    for (int blk = 0; blk < 12; blk++) begin
      bias = $urandom_range(0, 3);
      for (int n = 0; n < 250; n++)
        applyStimulus(2'($urandom_range(0, 3)), ($urandom_range(0, 3) < bias),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
      if (blk % 4 == 3) resetMid();
    end

    @(negedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
